operand_adder_ctrl: RTL and testbench

- Consumer side of the operand-entry interface of the peripherals unit.
- Drives loaddata high while operands are being keyed in and waits for inputdata_ready.
- Captures the 32-bit dataA/dataB, adds them byte-serially over one 8-bit adder slice with a carry chain, and returns the result on dataR.
- Then drops loaddata so the peripherals unit shows R0..R3 on the displays.

---
 rtl/operand_adder_ctrl_if.sv | 46 ++++
 rtl/operand_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_operand_adder_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/operand_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// operand_adder_ctrl_if
// Operand-entry bus between the peripherals unit (master) and the byte-serial
// operand adder (slave).
//   inputdata_ready : master -> slave, level, all operand bytes entered
//   dataA / dataB   : master -> slave, NBYTES*8-bit operands
//   op_sub          : master -> slave, subtract select (only with ADDER_SUB_EN)
//   loaddata        : slave -> master, 1 = entry mode, 0 = result display
//   dataR           : slave -> master, registered result
//   busy/done       : slave -> master, controller status
//   carry_out/overflow/zero : slave -> master, result flags
// Optional feature macro: ADDER_SUB_EN
// ---------------------------------------------------------------------------
interface operand_adder_ctrl_if #(
    parameter int NBYTES = 4
) ();
    logic                  inputdata_ready;
    logic [NBYTES*8-1:0]   dataA;
    logic [NBYTES*8-1:0]   dataB;
`ifdef ADDER_SUB_EN
    logic                  op_sub;
`endif
    logic                  loaddata;
    logic [NBYTES*8-1:0]   dataR;
    logic                  busy;
    logic                  done;
    logic                  carry_out;
    logic                  overflow;
    logic                  zero;

    modport master (
`ifdef ADDER_SUB_EN
        output op_sub,
`endif
        output inputdata_ready, dataA, dataB,
        input  loaddata, dataR, busy, done, carry_out, overflow, zero
    );

    modport slave (
`ifdef ADDER_SUB_EN
        input  op_sub,
`endif
        input  inputdata_ready, dataA, dataB,
        output loaddata, dataR, busy, done, carry_out, overflow, zero
    );
endinterface

// File: rtl/operand_adder_ctrl.sv
// ---------------------------------------------------------------------------
// operand_adder_ctrl
// Consumer side of the operand-entry interface. Holds loaddata high while the
// operands are keyed in, captures dataA/dataB once inputdata_ready is seen,
// adds them one byte lane per cycle through a single 8-bit slice with a
// carry chain, then drops loaddata so the displays show the result.
// DONE is terminal; only reset re-arms the controller.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : operand_adder_ctrl_if.slave (handshake, operands, result, flags)
// Optional feature macro: ADDER_SUB_EN (adds op_sub, computes A - B)
// ---------------------------------------------------------------------------
module operand_adder_ctrl #(
    parameter int NBYTES = 4,
    parameter int BYTE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    operand_adder_ctrl_if.slave  bus
);
    localparam int W     = NBYTES * BYTE_W;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ADD     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic [W-1:0]     r_datar;
    logic [IDX_W-1:0] r_byte_i;
    logic             r_carry;
    logic             r_loaddata;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W:0]   w_sum;
    logic [W-1:0]      w_new_r;
    logic [W-1:0]      w_cap_opb;
    logic              w_cap_carry;
    logic              w_ovf;

    // Byte-lane adder slice and the result as it will look after this edge.
    always_comb begin
        w_a_byte = r_opa[r_byte_i*BYTE_W +: BYTE_W];
        w_b_byte = r_opb[r_byte_i*BYTE_W +: BYTE_W];
        w_sum    = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {{BYTE_W{1'b0}}, r_carry};
        w_new_r  = r_datar;
        w_new_r[r_byte_i*BYTE_W +: BYTE_W] = w_sum[BYTE_W-1:0];
        // Signed overflow: same operand signs, result sign differs. For
        // subtraction r_opb already holds ~B, so its MSB is the inverted one.
        w_ovf    = (r_opa[W-1] == r_opb[W-1]) && (w_sum[BYTE_W-1] != r_opa[W-1]);
    end

    // Operand B and initial carry as captured (A - B = A + ~B + 1).
    always_comb begin
`ifdef ADDER_SUB_EN
        w_cap_opb   = bus.op_sub ? ~bus.dataB : bus.dataB;
        w_cap_carry = bus.op_sub;
`else
        w_cap_opb   = bus.dataB;
        w_cap_carry = 1'b0;
`endif
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_opa       <= {W{1'b0}};
            r_opb       <= {W{1'b0}};
            r_datar     <= {W{1'b0}};
            r_byte_i    <= {IDX_W{1'b0}};
            r_carry     <= 1'b0;
            r_loaddata  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    // Operands are still being keyed in; never sampled here.
                    r_loaddata <= 1'b1;
                    r_done     <= 1'b0;
                    if (bus.inputdata_ready) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_opa    <= bus.dataA;
                    r_opb    <= w_cap_opb;
                    r_byte_i <= {IDX_W{1'b0}};
                    r_carry  <= w_cap_carry;
                    r_datar  <= {W{1'b0}};
                    r_busy   <= 1'b1;
                    r_state  <= ST_ADD;
                end
                ST_ADD: begin
                    r_datar <= w_new_r;
                    r_carry <= w_sum[BYTE_W];
                    if (r_byte_i == LAST_IDX) begin
                        r_carry_out <= w_sum[BYTE_W];
                        r_overflow  <= w_ovf;
                        r_zero      <= (w_new_r == {W{1'b0}});
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_loaddata  <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_byte_i <= r_byte_i + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Terminal: result and flags frozen until reset.
                    r_loaddata <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_loaddata <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.loaddata  = r_loaddata;
    assign bus.dataR     = r_datar;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_operand_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_adder_ctrl
// Directed testbench for operand_adder_ctrl with hand-computed expectations.
// Optional feature macro: ADDER_SUB_EN (enables the subtraction vector)
// ---------------------------------------------------------------------------
module tb_operand_adder_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    operand_adder_ctrl_if #(.NBYTES(4)) bus ();

    operand_adder_ctrl #(.NBYTES(4), .BYTE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.inputdata_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Launch one operation and check latency, busy window and final result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_r,
                          input logic exp_c, input logic exp_v, input logic exp_z);
        int   done_at;
        int   busy_cnt;
        logic ld_pre;
        done_at  = -1;
        busy_cnt = 0;
        ld_pre   = 1'b0;
        @(negedge clk);
        bus.dataA = a;
        bus.dataB = b;
`ifdef ADDER_SUB_EN
        bus.op_sub = sub;
`else
        if (sub) $display("note: subtraction requested in add-only build");
`endif
        bus.inputdata_ready = 1'b1;
        // k = 0 is the edge that first samples inputdata_ready high (T0).
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (k == 4) ld_pre = bus.loaddata;
            if (bus.done && done_at < 0) done_at = k;
        end
        check_value({tag, ".done_at"},   32'(done_at), 32'd5);
        check_value({tag, ".busy_cnt"},  32'(busy_cnt), 32'd5);
        check_value({tag, ".ld_pre"},    {31'd0, ld_pre}, 32'd1);
        check_value({tag, ".loaddata"},  {31'd0, bus.loaddata}, 32'd0);
        check_value({tag, ".dataR"},     bus.dataR, exp_r);
        check_value({tag, ".carry_out"}, {31'd0, bus.carry_out}, {31'd0, exp_c});
        check_value({tag, ".overflow"},  {31'd0, bus.overflow}, {31'd0, exp_v});
        check_value({tag, ".zero"},      {31'd0, bus.zero}, {31'd0, exp_z});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        bus.inputdata_ready = 1'b0;
        bus.dataA = 32'h0;
        bus.dataB = 32'h0;
`ifdef ADDER_SUB_EN
        bus.op_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle in LOAD with changing operands and no ready.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.dataA = $urandom;
            bus.dataB = $urandom;
            @(posedge clk);
            #1;
            check_value("idle.loaddata", {31'd0, bus.loaddata}, 32'd1);
            check_value("idle.done",     {31'd0, bus.done}, 32'd0);
            check_value("idle.busy",     {31'd0, bus.busy}, 32'd0);
            check_value("idle.dataR",    bus.dataR, 32'h0);
        end

        // 0x01 + 0xFF: carry from lane 0 into lane 1.
        run_op("add1", 32'h0000_0001, 32'h0000_00FF, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        // Carry ripples through all four lanes and wraps.
        do_reset();
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Signed overflow, then result must stay frozen.
        do_reset();
        run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.dataA = 32'hDEAD_BEEF;
        bus.dataB = 32'h1234_5678;
        bus.inputdata_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("frozen.dataR",    bus.dataR, 32'h8000_0000);
        check_value("frozen.loaddata", {31'd0, bus.loaddata}, 32'd0);
        check_value("frozen.done",     {31'd0, bus.done}, 32'd1);

        // Reset in the second ADD cycle aborts asynchronously.
        do_reset();
        @(negedge clk);
        bus.dataA = 32'h0101_0101;
        bus.dataB = 32'h0101_0101;
        bus.inputdata_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("abort.pre_dataR", bus.dataR, 32'h0000_0002);
        check_value("abort.pre_busy",  {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_value("abort.loaddata", {31'd0, bus.loaddata}, 32'd1);
        check_value("abort.dataR",    bus.dataR, 32'h0);
        check_value("abort.busy",     {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.inputdata_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_op("after", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
        // 5 - 7 = -2 with a borrow.
        do_reset();
        run_op("sub", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
